uc_control: RTL and testbench
=============================

UC_CONTROL -- requirements
Module: uc_control

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all outputs are registered.
REQ-002 clk  input  1  rising-edge clock for all output registers.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 selector  input  5  instruction opcode bits [6:2].
REQ-005 Negative  input  1  ALU result-negative flag for the current branch comparison.
REQ-006 Branch  output  1  conditional-branch instruction.
REQ-007 Jump  output  1  unconditional jump (JAL).
REQ-008 PCSrc  output  1  1 = next PC is the target address; 0 = PC+4.
REQ-009 ImmSel  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-010 LUIOP  output  1  1 = write-back the U-immediate (LUI path, bypasses ImmSel).
REQ-011 WDSrc  output  1  1 = write-back PC+4; 0 = ALU/memory result.
REQ-012 ALUSrc  output  1  1 = ALU operand B is the immediate; 0 = rs2.
REQ-013 ALUOP  output  1  1 = ALU operation derived from funct3/funct7 downstream; 0 = forced ADD.
REQ-014 Mem2Reg  output  1  1 = write-back data-memory read data.
REQ-015 MemWrite  output  1  data-memory write strobe.
REQ-016 RegWriteEn  output  1  register-file write enable.

Function
REQ-017 On every rising clk edge, all outputs SHALL load the decode of the selector and Negative values present at that edge (1-cycle latency); the outputs hold between edges.
REQ-018 Selector 00000 (load) SHALL decode to ALUSrc=1, ImmSel=00, Mem2Reg=1, RegWriteEn=1, all others 0.
REQ-019 Selector 00100 (I-type ALU) SHALL decode to ALUSrc=1, ImmSel=00, ALUOP=1, RegWriteEn=1, all others 0.
REQ-020 Selector 01000 (store) SHALL decode to ALUSrc=1, ImmSel=01, MemWrite=1, all others 0.
REQ-021 Selector 01100 (R-type) SHALL decode to ALUOP=1, RegWriteEn=1, all others 0.
REQ-022 Selector 11000 (branch) SHALL decode to Branch=1, ImmSel=10, ALUOP=1, PCSrc=Negative, all others 0.
REQ-023 Selector 01101 (LUI) SHALL decode to LUIOP=1, RegWriteEn=1, ImmSel=00, all others 0.
REQ-024 Selector 11011 (JAL) SHALL decode to Jump=1, PCSrc=1, ImmSel=11, WDSrc=1, RegWriteEn=1, all others 0.
REQ-025 Every other selector value SHALL decode to all outputs 0 (NOP; no register or memory write).
REQ-026 Negative SHALL affect only PCSrc and only when selector=11000; it is ignored for all other selector values.
REQ-027 MemWrite and RegWriteEn SHALL never both be 1; Branch and Jump SHALL never both be 1.

Reset
REQ-028 While rst=1, all outputs SHALL be 0 immediately, regardless of clk.
REQ-029 After rst deasserts, the first rising clk edge SHALL load the decode of the current selector.
REQ-030 Asserting rst mid-operation SHALL zero all outputs at once, with no pending write strobe surviving.

Structure
REQ-031 The opcode selector constants (LOAD, OPIMM, STORE, OP, BRANCH, LUI, JAL) and the ImmSel encodings SHALL be defined in a shared package (uc_pkg).
REQ-032 The combinational decode SHALL be a sub-module, uc_decoder, whose outputs feed the output registers in uc_control.

Verification
REQ-033 rst=1, then release with selector=00000, Negative=0, one clock -> ALUSrc=1, Mem2Reg=1, RegWriteEn=1, ImmSel=00, all else 0.
REQ-034 selector=01000, one clock -> MemWrite=1, ALUSrc=1, ImmSel=01, RegWriteEn=0.
REQ-035 selector=11000 with Negative=1 -> Branch=1, PCSrc=1, ImmSel=10; with Negative=0 -> PCSrc=0.
REQ-036 selector=11011 -> Jump=1, PCSrc=1, WDSrc=1, ImmSel=11, RegWriteEn=1; selector=01101 -> LUIOP=1, RegWriteEn=1.
REQ-037 selector=11111 (illegal) -> all outputs 0; toggling Negative leaves PCSrc=0.
REQ-038 Assert rst between clock edges while selector=01000 -> MemWrite drops to 0 at once and stays 0 until the first edge after release.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared opcode selectors, immediate-format encodings and the decoded control
// bundle used by the main-control decoder and its output register stage.
package uc_pkg;

    localparam int SEL_W = 5;

    // Opcode bits [6:2]
    localparam logic [SEL_W-1:0] LOAD   = 5'b00000;
    localparam logic [SEL_W-1:0] OPIMM  = 5'b00100;
    localparam logic [SEL_W-1:0] STORE  = 5'b01000;
    localparam logic [SEL_W-1:0] OP     = 5'b01100;
    localparam logic [SEL_W-1:0] LUI    = 5'b01101;
    localparam logic [SEL_W-1:0] BRANCH = 5'b11000;
    localparam logic [SEL_W-1:0] JAL    = 5'b11011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       pcsrc;
        logic [1:0] immsel;
        logic       luiop;
        logic       wdsrc;
        logic       alusrc;
        logic       aluop;
        logic       mem2reg;
        logic       memwrite;
        logic       regwriteen;
    } uc_ctrl_t;

endpackage

// File: rtl/uc_decoder.sv
// Combinational main-control decode: opcode selector plus the branch compare
// flag in, control bundle out. Unknown selectors decode to an all-zero NOP.
module uc_decoder
    import uc_pkg::*;
(
    input  logic [SEL_W-1:0] selector,
    input  logic             negative,
    output uc_ctrl_t         ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (selector)
            LOAD: begin
                ctrl.alusrc     = 1'b1;
                ctrl.immsel     = IMM_I;
                ctrl.mem2reg    = 1'b1;
                ctrl.regwriteen = 1'b1;
            end
            OPIMM: begin
                ctrl.alusrc     = 1'b1;
                ctrl.immsel     = IMM_I;
                ctrl.aluop      = 1'b1;
                ctrl.regwriteen = 1'b1;
            end
            STORE: begin
                ctrl.alusrc   = 1'b1;
                ctrl.immsel   = IMM_S;
                ctrl.memwrite = 1'b1;
            end
            OP: begin
                ctrl.aluop      = 1'b1;
                ctrl.regwriteen = 1'b1;
            end
            BRANCH: begin
                // The ALU compare result is the only thing that makes a branch taken.
                ctrl.branch = 1'b1;
                ctrl.immsel = IMM_B;
                ctrl.aluop  = 1'b1;
                ctrl.pcsrc  = negative;
            end
            LUI: begin
                ctrl.luiop      = 1'b1;
                ctrl.immsel     = IMM_I;
                ctrl.regwriteen = 1'b1;
            end
            JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.pcsrc      = 1'b1;
                ctrl.immsel     = IMM_J;
                ctrl.wdsrc      = 1'b1;
                ctrl.regwriteen = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/uc_control.sv
// Registered main control: decodes selector/Negative every rising edge; an
// asynchronous reset clears every control output, including write strobes.
module uc_control
    import uc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] selector,
    input  logic             Negative,
    output logic             Branch,
    output logic             Jump,
    output logic             PCSrc,
    output logic [1:0]       ImmSel,
    output logic             LUIOP,
    output logic             WDSrc,
    output logic             ALUSrc,
    output logic             ALUOP,
    output logic             Mem2Reg,
    output logic             MemWrite,
    output logic             RegWriteEn
);

    uc_ctrl_t dec;
    uc_ctrl_t ctrl_q;

    uc_decoder u_dec (
        .selector (selector),
        .negative (Negative),
        .ctrl     (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= dec;
    end

    assign Branch     = ctrl_q.branch;
    assign Jump       = ctrl_q.jump;
    assign PCSrc      = ctrl_q.pcsrc;
    assign ImmSel     = ctrl_q.immsel;
    assign LUIOP      = ctrl_q.luiop;
    assign WDSrc      = ctrl_q.wdsrc;
    assign ALUSrc     = ctrl_q.alusrc;
    assign ALUOP      = ctrl_q.aluop;
    assign Mem2Reg    = ctrl_q.mem2reg;
    assign MemWrite   = ctrl_q.memwrite;
    assign RegWriteEn = ctrl_q.regwriteen;

endmodule

// File: tb/tb_uc_control.sv
// Directed bench for uc_control; expected control words are hand-encoded as
// {Branch,Jump,PCSrc,ImmSel[1:0],LUIOP,WDSrc,ALUSrc,ALUOP,Mem2Reg,MemWrite,RegWriteEn}.
module tb_uc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] selector;
    logic       Negative;
    logic       Branch, Jump, PCSrc, LUIOP, WDSrc, ALUSrc, ALUOP, Mem2Reg, MemWrite, RegWriteEn;
    logic [1:0] ImmSel;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [11:0] W_NOP    = 12'h000;
    localparam logic [11:0] W_LOAD   = 12'h015;
    localparam logic [11:0] W_OPIMM  = 12'h019;
    localparam logic [11:0] W_STORE  = 12'h092;
    localparam logic [11:0] W_OP     = 12'h009;
    localparam logic [11:0] W_BR_T   = 12'hB08;
    localparam logic [11:0] W_BR_N   = 12'h908;
    localparam logic [11:0] W_LUI    = 12'h041;
    localparam logic [11:0] W_JAL    = 12'h7A1;

    logic [11:0] word;
    logic [11:0] cur_exp;

    assign word = {Branch, Jump, PCSrc, ImmSel, LUIOP, WDSrc, ALUSrc, ALUOP,
                   Mem2Reg, MemWrite, RegWriteEn};

    always #5 clk = ~clk;

    uc_control dut (
        .clk        (clk),
        .rst        (rst),
        .selector   (selector),
        .Negative   (Negative),
        .Branch     (Branch),
        .Jump       (Jump),
        .PCSrc      (PCSrc),
        .ImmSel     (ImmSel),
        .LUIOP      (LUIOP),
        .WDSrc      (WDSrc),
        .ALUSrc     (ALUSrc),
        .ALUOP      (ALUOP),
        .Mem2Reg    (Mem2Reg),
        .MemWrite   (MemWrite),
        .RegWriteEn (RegWriteEn)
    );

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    endtask

    // Drive mid-cycle, confirm outputs still hold the old decode, then check
    // the new decode one edge later plus the mutual-exclusion invariants.
    task automatic step(input string tag, input logic [4:0] sel, input logic neg,
                        input logic [11:0] exp);
        @(negedge clk);
        selector = sel;
        Negative = neg;
        #1 chk({tag, "_hold"}, word, cur_exp);
        @(posedge clk);
        #1 chk(tag, word, exp);
        chk({tag, "_excl"}, {10'd0, MemWrite & RegWriteEn, Branch & Jump}, 12'h000);
        cur_exp = exp;
    endtask

    initial begin
        rst      = 1'b1;
        selector = 5'b00000;
        Negative = 1'b0;
        cur_exp  = W_NOP;
        #1 chk("rst_async", word, W_NOP);
        @(posedge clk);
        #1 chk("rst_edge", word, W_NOP);

        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_rel_hold", word, W_NOP);
        @(posedge clk);
        #1 chk("first_load", word, W_LOAD);
        cur_exp = W_LOAD;

        step("store",    5'b01000, 1'b0, W_STORE);
        step("opimm",    5'b00100, 1'b0, W_OPIMM);
        step("op",       5'b01100, 1'b1, W_OP);
        step("br_taken", 5'b11000, 1'b1, W_BR_T);
        step("br_not",   5'b11000, 1'b0, W_BR_N);
        step("jal",      5'b11011, 1'b0, W_JAL);
        step("jal_neg",  5'b11011, 1'b1, W_JAL);
        step("lui",      5'b01101, 1'b1, W_LUI);
        step("ill_n0",   5'b11111, 1'b0, W_NOP);
        step("ill_n1",   5'b11111, 1'b1, W_NOP);
        step("jalr_nop", 5'b11001, 1'b1, W_NOP);
        step("auipc_nop",5'b00101, 1'b0, W_NOP);
        step("load_neg", 5'b00000, 1'b1, W_LOAD);
        step("store2",   5'b01000, 1'b0, W_STORE);

        // Reset between edges while a store is decoded.
        #2 rst = 1'b1;
        #1 chk("rst_mid", word, W_NOP);
        @(posedge clk);
        #1 chk("rst_mid_edge", word, W_NOP);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_mid_rel", word, W_NOP);
        @(posedge clk);
        #1 chk("post_rst_store", word, W_STORE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
